// File: rtl/mux_scan_sequencer_if.sv
// -----------------------------------------------------------------------------
// mux_scan_sequencer_if
// Bundles every non-clock signal between the scan sequencer, the 16:1 channel
// multiplexer it drives, the control side that starts/stops sweeps and the
// downstream sample consumer.
//
//   start       controller -> seq   begin a sweep (honoured only when idle)
//   continuous  controller -> seq   restart from channel 0 after each sweep
//   abort       controller -> seq   synchronous stop, back to idle
//   chan_mask   controller -> seq   per-channel enable, latched at sweep start
//   select      seq -> mux          registered channel select
//   mux_data    mux -> seq          multiplexer output
//   out_valid   seq -> consumer     sample available
//   out_ready   consumer -> seq     sample accepted
//   out_data    seq -> consumer     captured sample
//   out_chan    seq -> consumer     channel the sample came from
//   busy        seq -> controller   high whenever a sweep is in progress
//   done        seq -> controller   one-cycle pulse at the end of each sweep
//
// slave  : the sequencer's view.
// master : the surrounding system's view (controller, mux and consumer).
// -----------------------------------------------------------------------------
interface mux_scan_sequencer_if #(
  parameter int DATA_W = 6,
  parameter int SEL_W  = 4
);
  localparam int NCH = 2 ** SEL_W;

  logic              start;
  logic              continuous;
  logic              abort;
  logic [NCH-1:0]    chan_mask;
  logic [SEL_W-1:0]  select;
  logic [DATA_W-1:0] mux_data;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [SEL_W-1:0]  out_chan;
  logic              busy;
  logic              done;

  modport slave (
    input  start, continuous, abort, chan_mask, mux_data, out_ready,
    output select, out_valid, out_data, out_chan, busy, done
  );

  modport master (
    output start, continuous, abort, chan_mask, mux_data, out_ready,
    input  select, out_valid, out_data, out_chan, busy, done
  );
endinterface

// File: rtl/mux_scan_sequencer.sv
// -----------------------------------------------------------------------------
// mux_scan_sequencer
// Upstream controller for a 2**SEL_W : 1 channel multiplexer. Walks the enabled
// channels of a latched mask in ascending order, holds each select value for
// SETTLE extra cycles, samples the mux output and offers it with its channel
// number on a valid/ready stream. Single-sweep or continuous operation.
//
// Ports:
//   clk    system clock, rising edge
//   rst_n  asynchronous active-low reset
//   bus    mux_scan_sequencer_if.slave (control, mux and stream signals)
//
// Parameters:
//   DATA_W  mux data width
//   SEL_W   select width, channel count is 2**SEL_W
//   SETTLE  extra settle cycles before sampling, 0..15
// -----------------------------------------------------------------------------
module mux_scan_sequencer #(
  parameter int DATA_W = 6,
  parameter int SEL_W  = 4,
  parameter int SETTLE = 1
) (
  input logic                  clk,
  input logic                  rst_n,
  mux_scan_sequencer_if.slave  bus
);

  localparam int NCH   = 2 ** SEL_W;
  localparam int CUR_W = SEL_W + 1;   // must reach NCH to mark "past last channel"
  localparam int CNT_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEEK = 2'd1,
    ST_WAIT = 2'd2,
    ST_HOLD = 2'd3
  } state_t;

  state_t            state_q;
  logic [NCH-1:0]    mask_q;
  logic [CUR_W-1:0]  cur_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [SEL_W-1:0]  select_q;
  logic              out_valid_q;
  logic [DATA_W-1:0] out_data_q;
  logic [SEL_W-1:0]  out_chan_q;
  logic              busy_q;
  logic              done_q;

  logic [NCH-1:0]    eligible_s;
  logic              seek_hit_s;
  logic [SEL_W-1:0]  seek_chan_s;

  // Lowest set bit of vec; result MSB flags that any bit was set.
  function automatic logic [SEL_W:0] find_lowest(input logic [NCH-1:0] vec);
    logic [SEL_W:0] res;
    res = '0;
    // Scan downwards so the last hit written is the lowest index.
    for (int i = NCH - 1; i >= 0; i--) begin
      res = vec[i] ? {1'b1, SEL_W'(i)} : res;
    end
    return res;
  endfunction

  // Channel search: enabled channels at or above the search base.
  always_comb begin
    eligible_s  = '0;
    seek_hit_s  = 1'b0;
    seek_chan_s = '0;
    // A base of NCH shifts every bit out, which ends the sweep.
    eligible_s  = mask_q & ({NCH{1'b1}} << cur_q);
    {seek_hit_s, seek_chan_s} = find_lowest(eligible_s);
  end

  // Sequencer FSM with all outputs registered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      mask_q      <= '0;
      cur_q       <= '0;
      cnt_q       <= '0;
      select_q    <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_chan_q  <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (bus.abort) begin
        // Select and the last sample stay put; only the stream and status drop.
        state_q     <= ST_IDLE;
        out_valid_q <= 1'b0;
        busy_q      <= 1'b0;
      end else begin
        case (state_q)
          ST_IDLE: begin
            if (bus.start) begin
              mask_q  <= bus.chan_mask;
              cur_q   <= '0;
              busy_q  <= 1'b1;
              state_q <= ST_SEEK;
            end else begin
              busy_q  <= 1'b0;
            end
          end
          ST_SEEK: begin
            if (seek_hit_s) begin
              select_q <= seek_chan_s;
              cnt_q    <= CNT_W'(SETTLE);
              state_q  <= ST_WAIT;
            end else begin
              done_q <= 1'b1;
              if (bus.continuous && (bus.chan_mask != {NCH{1'b0}})) begin
                mask_q <= bus.chan_mask;
                cur_q  <= '0;
              end else begin
                busy_q  <= 1'b0;
                state_q <= ST_IDLE;
              end
            end
          end
          ST_WAIT: begin
            if (cnt_q == CNT_W'(0)) begin
              out_data_q  <= bus.mux_data;
              out_chan_q  <= select_q;
              out_valid_q <= 1'b1;
              state_q     <= ST_HOLD;
            end else begin
              cnt_q <= cnt_q - CNT_W'(1);
            end
          end
          ST_HOLD: begin
            if (bus.out_ready) begin
              out_valid_q <= 1'b0;
              // Channel NCH-1 yields cur = NCH, so the next search is empty.
              cur_q       <= {1'b0, select_q} + CUR_W'(1);
              state_q     <= ST_SEEK;
            end else begin
              out_valid_q <= 1'b1;
            end
          end
          default: begin
            state_q     <= ST_IDLE;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.select    = select_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_chan  = out_chan_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;

endmodule
